// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Sequencing FSM for a multi-cycle MIPS datapath with memory
//            handshake stalls and a retired-instruction counter.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op_code,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   pcWriteCond,
    output logic [1:0]             branchType,
    output logic [1:0]             pcSrc,
    output logic                   iorD,
    output logic                   memRead,
    output logic                   memWrite,
    output logic                   irWrite,
    output logic                   regDst,
    output logic                   memToReg,
    output logic                   regWrite,
    output logic                   aluSrcA,
    output logic [1:0]             aluSrcB,
    output logic [2:0]             aluOp,
    output logic [3:0]             state,
    output logic                   illegalOp,
    output logic                   instrRetired,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEX    = 4'd6,
        ALUWB   = 4'd7,
        IMMEX   = 4'd8,
        BRANCH  = 4'd9,
        ILLEGAL = 4'd10
    } state_t;

    localparam logic [5:0] c_opRtype = 6'b000000;
    localparam logic [5:0] c_opLw    = 6'b100011;
    localparam logic [5:0] c_opSw    = 6'b101011;
    localparam logic [5:0] c_opBeq   = 6'b000100;
    localparam logic [5:0] c_opBne   = 6'b000101;
    localparam logic [5:0] c_opBgtz  = 6'b000111;
    localparam logic [5:0] c_opAddi  = 6'b001000;
    localparam logic [5:0] c_opAndi  = 6'b001100;
    localparam logic [5:0] c_opOri   = 6'b001101;
    localparam logic [5:0] c_opSlti  = 6'b001010;

    localparam logic [COUNT_WIDTH-1:0] c_countOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       pcWriteCond;
        logic [1:0] branchType;
        logic [1:0] pcSrc;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       illegalOp;
    } ctrl_t;

    // Control word that depends only on the state and the latched opcode.
    function automatic ctrl_t decodeCtrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
            end
            DECODE: c.aluSrcB = 2'b11;
            MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEMWB: begin
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            RTEX: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 3'b010;
            end
            ALUWB: begin
                c.regWrite = 1'b1;
                c.regDst   = (op == c_opRtype);
            end
            IMMEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                case (op)
                    c_opAndi: c.aluOp = 3'b101;
                    c_opOri:  c.aluOp = 3'b011;
                    c_opSlti: c.aluOp = 3'b100;
                    default:  c.aluOp = 3'b000;
                endcase
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 3'b001;
                c.pcWriteCond = 1'b1;
                c.pcSrc       = 2'b01;
                case (op)
                    c_opBne:  c.branchType = 2'b01;
                    c_opBgtz: c.branchType = 2'b10;
                    default:  c.branchType = 2'b00;
                endcase
            end
            ILLEGAL: c.illegalOp = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t                 r_state;
    logic [5:0]             r_opReg;
    logic [COUNT_WIDTH-1:0] r_instrCount;
    ctrl_t                  r_ctrl;

    state_t     w_nextState;
    logic [5:0] w_nextOp;
    logic       w_retire;
    logic       w_live;

    always_comb begin
        w_nextState = FETCH;
        w_nextOp    = r_opReg;
        case (r_state)
            FETCH:  w_nextState = memReady ? DECODE : FETCH;
            DECODE: begin
                w_nextOp = op_code;
                case (op_code)
                    c_opRtype:                             w_nextState = RTEX;
                    c_opLw, c_opSw:                        w_nextState = MEMADR;
                    c_opBeq, c_opBne, c_opBgtz:            w_nextState = BRANCH;
                    c_opAddi, c_opAndi, c_opOri, c_opSlti: w_nextState = IMMEX;
                    default:                               w_nextState = ILLEGAL;
                endcase
            end
            MEMADR:  w_nextState = (r_opReg == c_opLw) ? MEMRD : MEMWR;
            MEMRD:   w_nextState = memReady ? MEMWB : MEMRD;
            MEMWB:   w_nextState = FETCH;
            MEMWR:   w_nextState = memReady ? FETCH : MEMWR;
            RTEX:    w_nextState = ALUWB;
            IMMEX:   w_nextState = ALUWB;
            ALUWB:   w_nextState = FETCH;
            BRANCH:  w_nextState = FETCH;
            ILLEGAL: w_nextState = FETCH;
            default: w_nextState = FETCH;
        endcase
    end

    assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BRANCH) ||
                      ((r_state == MEMWR) && memReady);

    // Control word is pre-decoded for the state being entered, so it changes
    // cleanly on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_opReg      <= 6'd0;
            r_instrCount <= '0;
            r_ctrl       <= decodeCtrl(FETCH, 6'd0);
        end else begin
            r_state <= w_nextState;
            r_opReg <= w_nextOp;
            r_ctrl  <= decodeCtrl(w_nextState, w_nextOp);
            if (w_retire) begin
                r_instrCount <= r_instrCount + c_countOne;
            end
        end
    end

    // Reset blanks every output asynchronously; unused codes drive nothing.
    assign w_live = !reset && (r_state <= ILLEGAL);

    assign pcWriteCond  = w_live & r_ctrl.pcWriteCond;
    assign branchType   = w_live ? r_ctrl.branchType : 2'b00;
    assign pcSrc        = w_live ? r_ctrl.pcSrc : 2'b00;
    assign iorD         = w_live & r_ctrl.iorD;
    assign memRead      = w_live & r_ctrl.memRead;
    assign memWrite     = w_live & r_ctrl.memWrite;
    assign regDst       = w_live & r_ctrl.regDst;
    assign memToReg     = w_live & r_ctrl.memToReg;
    assign regWrite     = w_live & r_ctrl.regWrite;
    assign aluSrcA      = w_live & r_ctrl.aluSrcA;
    assign aluSrcB      = w_live ? r_ctrl.aluSrcB : 2'b00;
    assign aluOp        = w_live ? r_ctrl.aluOp : 3'b000;
    assign illegalOp    = w_live & r_ctrl.illegalOp;
    assign pcWrite      = w_live && (r_state == FETCH) && memReady;
    assign irWrite      = w_live && (r_state == FETCH) && memReady;
    assign instrRetired = w_live && w_retire;
    assign state        = r_state;
    assign instrCount   = r_instrCount;

endmodule
`default_nettype wire
